// File: rtl/fifo_pkt_arbiter_pkg.sv
// fifo_pkt_arbiter_pkg: arbiter state type, default timeout and the round-robin pick function
// shared by fifo_pkt_arbiter and its priority-pick sub-module.
package fifo_pkt_arbiter_pkg;
  typedef enum logic {IDLE, BURST} state_e;
  localparam int TIMEOUT_CYC_DEF = 1024;
  localparam int MAX_REQ = 8;
  // Nearest valid index above last_owner, wrapping at n; returns last_owner when none is valid.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid, input logic [2:0] last_owner, input int n);
    int s;
    logic [2:0] c;
    logic [2:0] pick;
    pick = last_owner;
    for (int k = MAX_REQ; k >= 1; k--) begin
      s = int'(last_owner) + k;
      if (s >= n) s = s - n;
      c = 3'(s);
      if (k <= n && valid[c]) pick = c;
    end
    return pick;
  endfunction
endpackage

// File: rtl/fifo_pkt_arbiter_if.sv
// fifo_pkt_arbiter_if: requester-side and FIFO-write-side signals of the packet arbiter.
// master drives requests and fifo_full; slave is the arbiter.
interface fifo_pkt_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]         fifo_wr_data;
  logic                     fifo_wr_en;
  logic                     fifo_full;
  logic [NUM_REQ-1:0]       grant;
  logic                     pkt_done;
  logic                     timeout_err;
  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_data, fifo_wr_en, grant, pkt_done, timeout_err
  );
  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_data, fifo_wr_en, grant, pkt_done, timeout_err
  );
endinterface

// File: rtl/fifo_pkt_arbiter_rr_priority_pick.sv
// fifo_pkt_arbiter_rr_priority_pick: rotate-and-priority-encode, picks the next valid index
// after last_i with wrap and flags whether any was found.
module fifo_pkt_arbiter_rr_priority_pick
  import fifo_pkt_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);
  logic [MAX_REQ-1:0] v;
  always_comb begin
    v = '0;
    v[NUM_REQ-1:0] = valid_i;
    idx_o = IDX_W'(rr_pick(v, 3'(last_i), NUM_REQ));
    found_o = |valid_i;
  end
endmodule

// File: rtl/fifo_pkt_arbiter.sv
// fifo_pkt_arbiter: packet-granular round-robin arbiter in front of a sync_fifo write port.
// Optional stall timeout enabled by defining FIFO_ARB_TIMEOUT_EN.
module fifo_pkt_arbiter
  import fifo_pkt_arbiter_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NUM_REQ     = 4,
  parameter int IDX_W       = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic clk,
  input logic rst_n,
  fifo_pkt_arbiter_if.slave arb_if
);
  state_e state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] owner_q, owner_d, pick;
  logic found, burst, beat, done, tout, pkt_done_q;

  fifo_pkt_arbiter_rr_priority_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .valid_i (arb_if.req_valid),
    .last_i  (owner_q),
    .idx_o   (pick),
    .found_o (found)
  );

  // Data path is combinational from the owner straight to the FIFO write port.
  always_comb begin
    burst = state_q == BURST;
    arb_if.req_ready = (burst && !arb_if.fifo_full) ? grant_q : '0;
    beat = |(arb_if.req_valid & arb_if.req_ready);
    done = beat && arb_if.req_last[owner_q];
    arb_if.fifo_wr_en = beat;
    arb_if.fifo_wr_data = arb_if.req_data[int'(owner_q)*WIDTH +: WIDTH];
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    if (!burst && found) begin
      state_d = BURST;
      grant_d = NUM_REQ'(1) << pick;
      owner_d = pick;
    end else if (burst && (done || tout)) begin
      state_d = IDLE;
      grant_d = '0;
    end
  end

`ifdef FIFO_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic stall;
  // Owner valid but FIFO full is back-pressure, not a stall: the count is held there.
  always_comb begin
    stall = state_q == BURST && !arb_if.req_valid[owner_q];
    tout = stall && cnt_q == CNT_W'(TIMEOUT_CYC - 1);
    cnt_d = (tout || state_q != BURST || (!stall && !arb_if.fifo_full)) ? '0 :
            stall ? cnt_q + 1'b1 : cnt_q;
    arb_if.timeout_err = tout;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  always_comb begin
    tout = 1'b0;
    arb_if.timeout_err = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      pkt_done_q <= done;
    end

  assign arb_if.grant = grant_q;
  assign arb_if.pkt_done = pkt_done_q;
endmodule

// File: tb/tb_fifo_pkt_arbiter.sv
// tb_fifo_pkt_arbiter: directed self-checking bench for fifo_pkt_arbiter (NUM_REQ=4, TIMEOUT_CYC=16).
module tb_fifo_pkt_arbiter;
  localparam int W = 8;
  localparam int NR = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [7:0] wq[$];
  int gq[$];
  int done_cnt = 0;
  logic [8:0] pq[NR][$];
  logic [NR-1:0] prev_grant = '0;

  fifo_pkt_arbiter_if #(.WIDTH(W), .NUM_REQ(NR)) bus ();
  fifo_pkt_arbiter #(.WIDTH(W), .NUM_REQ(NR), .TIMEOUT_CYC(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_if (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && bus.fifo_wr_en) wq.push_back(bus.fifo_wr_data);
    if (bus.pkt_done) done_cnt++;
    if (bus.grant != '0 && prev_grant == '0)
      for (int i = 0; i < NR; i++) if (bus.grant[i]) gq.push_back(i);
    prev_grant = bus.grant;
  end

  assert property (@(posedge clk) $onehot0(bus.grant));

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
    checks++;
    if (!$onehot0(bus.grant)) begin
      errors++;
      $display("FAIL onehot: grant=%b required one-hot or zero", bus.grant);
    end
  endtask

  task automatic do_reset;
    bus.req_valid = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    bus.fifo_full = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_stream(input int n);
    logic [NR-1:0] acc;
    acc = '0;
    for (int c = 0; c < n; c++) begin
      tick();
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) void'(pq[i].pop_front());
        bus.req_valid[i] = pq[i].size() != 0;
        bus.req_data[i*W +: W] = bus.req_valid[i] ? pq[i][0][7:0] : 8'h00;
        bus.req_last[i] = bus.req_valid[i] && pq[i][0][8];
      end
      #1;
      acc = bus.req_valid & bus.req_ready;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.fifo_full = 1'b0;
    bus.req_data = '0;
    bus.req_valid = '1;
    bus.req_last = '1;
    tick();
    tick();
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got=%b exp=0000", bus.grant); end
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got=%b exp=0000", bus.req_ready); end
    checks++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got=%b exp=0", bus.fifo_wr_en); end
    checks++; if (bus.pkt_done !== 1'b0) begin errors++; $display("FAIL reset_pkt_done: got=%b exp=0", bus.pkt_done); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got=%b exp=0", bus.timeout_err); end
    rst_n = 1'b1;
    bus.req_valid = '0;
    tick();
    tick();
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL last_without_valid_grant: got=%b exp=0000", bus.grant); end
    checks++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL last_without_valid_wr: got=%b exp=0", bus.fifo_wr_en); end
    bus.req_last = '0;
  endtask

  task automatic test_single_pkt;
    int wb, db;
    wb = wq.size();
    db = done_cnt;
    tick();
    bus.req_valid = 4'b0100;
    bus.req_data[16 +: 8] = 8'hA1;
    bus.req_last = '0;
    #1;
    checks++; if (bus.grant !== 4'b0000 || bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL single_arb_bubble: grant=%b wr_en=%b exp 0000/0", bus.grant, bus.fifo_wr_en); end
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.req_data[16 +: 8] = 8'hA1 + 8'(i);
      bus.req_last[2] = (i == 2);
      #1;
      checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL single_grant[%0d]: got=%b exp=0100", i, bus.grant); end
      checks++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wr_data !== 8'hA1 + 8'(i)) begin errors++; $display("FAIL single_write[%0d]: wr_en=%b data=%h exp 1/%h", i, bus.fifo_wr_en, bus.fifo_wr_data, 8'hA1 + 8'(i)); end
    end
    tick();
    bus.req_valid = '0;
    bus.req_last = '0;
    #1;
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL single_grant_clear: got=%b exp=0000", bus.grant); end
    checks++; if (bus.pkt_done !== 1'b1) begin errors++; $display("FAIL single_pkt_done: got=%b exp=1", bus.pkt_done); end
    checks++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL single_no_extra_write: got=%b exp=0", bus.fifo_wr_en); end
    tick();
    checks++; if (bus.pkt_done !== 1'b0) begin errors++; $display("FAIL single_pkt_done_pulse: got=%b exp=0", bus.pkt_done); end
    checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL single_done_count: got=%0d exp=1", done_cnt - db); end
    checks++; if (wq.size() - wb !== 3) begin errors++; $display("FAIL single_write_count: got=%0d exp=3", wq.size() - wb); end
  endtask

  task automatic test_rr_pair;
    int wb, gb, db;
    logic [7:0] exp_b[4];
    logic [7:0] got;
    do_reset();
    wb = wq.size();
    gb = gq.size();
    db = done_cnt;
    exp_b = '{8'hC0, 8'hC1, 8'hB0, 8'hB1};
    pq[0] = '{9'h0B0, 9'h1B1};
    pq[1] = '{9'h0C0, 9'h1C1};
    run_stream(10);
    checks++; if (wq.size() - wb !== 4) begin errors++; $display("FAIL pair_write_count: got=%0d exp=4", wq.size() - wb); end
    for (int i = 0; i < 4; i++) begin
      got = (wb + i < wq.size()) ? wq[wb + i] : 8'hxx;
      checks++; if (got !== exp_b[i]) begin errors++; $display("FAIL pair_order[%0d]: got=%h exp=%h", i, got, exp_b[i]); end
    end
    checks++; if (gq.size() - gb !== 2) begin errors++; $display("FAIL pair_grant_count: got=%0d exp=2", gq.size() - gb); end
    else begin
      checks++; if (gq[gb] !== 1 || gq[gb + 1] !== 0) begin errors++; $display("FAIL pair_grant_seq: got=%0d,%0d exp=1,0", gq[gb], gq[gb + 1]); end
    end
    checks++; if (done_cnt - db !== 2) begin errors++; $display("FAIL pair_done_count: got=%0d exp=2", done_cnt - db); end
  endtask

  task automatic test_fifo_full;
    int wb;
    logic [7:0] got;
    wb = wq.size();
    tick();
    bus.req_valid = 4'b1000;
    bus.req_data[24 +: 8] = 8'h10;
    bus.req_last = '0;
    #1;
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL full_arb_bubble: got=%b exp=0000", bus.grant); end
    tick();
    checks++; if (bus.grant !== 4'b1000 || bus.fifo_wr_data !== 8'h10 || bus.fifo_wr_en !== 1'b1) begin errors++; $display("FAIL full_first: grant=%b wr_en=%b data=%h exp 1000/1/10", bus.grant, bus.fifo_wr_en, bus.fifo_wr_data); end
    for (int k = 0; k < 5; k++) begin
      tick();
      bus.req_data[24 +: 8] = 8'h11;
      bus.fifo_full = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 4'b0000 || bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL full_stall[%0d]: ready=%b wr_en=%b exp 0000/0", k, bus.req_ready, bus.fifo_wr_en); end
      checks++; if (bus.grant !== 4'b1000) begin errors++; $display("FAIL full_grant_hold[%0d]: got=%b exp=1000", k, bus.grant); end
    end
    tick();
    bus.fifo_full = 1'b0;
    #1;
    checks++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wr_data !== 8'h11) begin errors++; $display("FAIL full_resume: wr_en=%b data=%h exp 1/11", bus.fifo_wr_en, bus.fifo_wr_data); end
    tick();
    bus.req_data[24 +: 8] = 8'h12;
    bus.req_last[3] = 1'b1;
    #1;
    tick();
    bus.req_valid = '0;
    bus.req_last = '0;
    #1;
    checks++; if (bus.grant !== 4'b0000 || bus.pkt_done !== 1'b1) begin errors++; $display("FAIL full_end: grant=%b pkt_done=%b exp 0000/1", bus.grant, bus.pkt_done); end
    checks++; if (wq.size() - wb !== 3) begin errors++; $display("FAIL full_write_count: got=%0d exp=3", wq.size() - wb); end
    for (int i = 0; i < 3; i++) begin
      got = (wb + i < wq.size()) ? wq[wb + i] : 8'hxx;
      checks++; if (got !== 8'h10 + 8'(i)) begin errors++; $display("FAIL full_order[%0d]: got=%h exp=%h", i, got, 8'h10 + 8'(i)); end
    end
  endtask

  task automatic test_rr_all;
    int wb, gb, db;
    logic [7:0] got;
    int gi;
    do_reset();
    wb = wq.size();
    gb = gq.size();
    db = done_cnt;
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 2; k++) pq[i].push_back({1'b1, 8'(64 + 16*i + k)});
    run_stream(20);
    checks++; if (gq.size() - gb !== 8) begin errors++; $display("FAIL all_grant_count: got=%0d exp=8", gq.size() - gb); end
    checks++; if (wq.size() - wb !== 8) begin errors++; $display("FAIL all_write_count: got=%0d exp=8", wq.size() - wb); end
    checks++; if (done_cnt - db !== 8) begin errors++; $display("FAIL all_done_count: got=%0d exp=8", done_cnt - db); end
    for (int n = 0; n < 8; n++) begin
      gi = (gb + n < gq.size()) ? gq[gb + n] : -1;
      got = (wb + n < wq.size()) ? wq[wb + n] : 8'hxx;
      checks++; if (gi !== (n + 1) % 4) begin errors++; $display("FAIL all_grant[%0d]: got=%0d exp=%0d", n, gi, (n + 1) % 4); end
      checks++; if (got !== 8'(64 + 16*((n + 1) % 4) + n/4)) begin errors++; $display("FAIL all_data[%0d]: got=%h exp=%h", n, got, 8'(64 + 16*((n + 1) % 4) + n/4)); end
    end
  endtask

  task automatic test_reset_mid;
    tick();
    bus.req_valid = 4'b0100;
    bus.req_data[16 +: 8] = 8'hD0;
    bus.req_last = '0;
    #1;
    tick();
    checks++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wr_data !== 8'hD0) begin errors++; $display("FAIL mid_first_byte: wr_en=%b data=%h exp 1/D0", bus.fifo_wr_en, bus.fifo_wr_data); end
    tick();
    bus.req_data[16 +: 8] = 8'hD1;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL mid_rst_grant: got=%b exp=0000", bus.grant); end
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready: got=%b exp=0000", bus.req_ready); end
    checks++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL mid_rst_wr_en: got=%b exp=0", bus.fifo_wr_en); end
    tick();
    tick();
    rst_n = 1'b1;
    bus.req_valid = 4'b0101;
    #1;
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL mid_post_idle: got=%b exp=0000", bus.grant); end
    tick();
    checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL mid_rr_restart: got=%b exp=0100", bus.grant); end
    do_reset();
  endtask

  task automatic test_timeout;
    do_reset();
    tick();
    bus.req_valid = 4'b0110;
    bus.req_data[8 +: 8] = 8'hE0;
    bus.req_data[16 +: 8] = 8'hF0;
    bus.req_last = 4'b0100;
    #1;
    tick();
    checks++; if (bus.grant !== 4'b0010 || bus.fifo_wr_data !== 8'hE0 || bus.fifo_wr_en !== 1'b1) begin errors++; $display("FAIL to_first: grant=%b wr_en=%b data=%h exp 0010/1/E0", bus.grant, bus.fifo_wr_en, bus.fifo_wr_data); end
    tick();
    bus.req_valid[1] = 1'b0;
    #1;
`ifdef FIFO_ARB_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) tick();
      checks++; if (bus.timeout_err !== (k == 16)) begin errors++; $display("FAIL to_err[%0d]: got=%b exp=%b", k, bus.timeout_err, k == 16); end
      checks++; if (bus.grant !== 4'b0010 || bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL to_hold[%0d]: grant=%b wr_en=%b exp 0010/0", k, bus.grant, bus.fifo_wr_en); end
    end
    tick();
    checks++; if (bus.grant !== 4'b0000 || bus.timeout_err !== 1'b0 || bus.pkt_done !== 1'b0) begin errors++; $display("FAIL to_revoke: grant=%b err=%b pkt_done=%b exp 0000/0/0", bus.grant, bus.timeout_err, bus.pkt_done); end
    tick();
    checks++; if (bus.grant !== 4'b0100 || bus.fifo_wr_data !== 8'hF0) begin errors++; $display("FAIL to_next_owner: grant=%b data=%h exp 0100/F0", bus.grant, bus.fifo_wr_data); end
`else
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) tick();
      checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL to_err[%0d]: got=%b exp=0", k, bus.timeout_err); end
      checks++; if (bus.grant !== 4'b0010 || bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL to_hold[%0d]: grant=%b wr_en=%b exp 0010/0", k, bus.grant, bus.fifo_wr_en); end
    end
    tick();
    bus.req_valid[1] = 1'b1;
    bus.req_data[8 +: 8] = 8'hE1;
    bus.req_last[1] = 1'b1;
    #1;
    checks++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wr_data !== 8'hE1) begin errors++; $display("FAIL to_resume: wr_en=%b data=%h exp 1/E1", bus.fifo_wr_en, bus.fifo_wr_data); end
    tick();
    bus.req_valid[1] = 1'b0;
    bus.req_last[1] = 1'b0;
    #1;
    checks++; if (bus.grant !== 4'b0000 || bus.pkt_done !== 1'b1) begin errors++; $display("FAIL to_end: grant=%b pkt_done=%b exp 0000/1", bus.grant, bus.pkt_done); end
`endif
    tick();
    bus.req_valid = '0;
    bus.req_last = '0;
  endtask

  initial begin
    test_reset();
    test_single_pkt();
    test_rr_pair();
    test_fifo_full();
    test_rr_all();
    test_reset_mid();
    test_timeout();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_pkt_arbiter.md
Name: fifo_pkt_arbiter

Overview:
- Round-robin arbiter that shares one sync_fifo write port between NUM_REQ byte-stream requesters, e.g. the USB-report, command-response and debug sources feeding the UART TX FIFO.
- Arbitrates at packet granularity: once a requester is granted, its bytes go to the FIFO contiguously until its last byte, so packets never interleave.
- Sits directly in front of the FIFO write interface and honours its full flag.

Parameters:
- WIDTH, 8, data byte width; must match the downstream FIFO WIDTH.
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, $clog2(NUM_REQ), width of the round-robin pointer.
- TIMEOUT_CYC, 1024, stall limit in cycles; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  NUM_REQ*WIDTH  per-requester byte; requester i uses bits [i*WIDTH +: WIDTH].
- req_last  input  NUM_REQ  marks the final byte of a packet; qualified by req_valid.
- req_ready  output  NUM_REQ  byte accepted when req_valid[i] && req_ready[i].
- fifo_wr_data  output  WIDTH  to FIFO wr_data.
- fifo_wr_en  output  1  to FIFO wr_en.
- fifo_full  input  1  from FIFO full.
- grant  output  NUM_REQ  one-hot current owner; all zero when idle.
- pkt_done  output  1  one-cycle pulse when a last byte is written.
- timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Interface: one clock (clk); asynchronous active-low reset (rst_n).
- Reset values:
  - state=IDLE, grant=0, rr_ptr=0.
  - req_ready=0, fifo_wr_en=0, pkt_done=0, timeout_err=0.
  - stall counter=0.
- State IDLE:
  - If any req_valid is high, select the first requester with req_valid set, searching from (last_owner+1) mod NUM_REQ upward with wrap.
  - Register the one-hot grant, set last_owner=index, go to BURST.
  - Arbitration cost is 1 cycle; no byte moves in IDLE.
- State BURST:
  - req_ready[i] = grant[i] && !fifo_full, combinational; all non-granted ready=0.
  - beat = |(req_valid & req_ready).
  - fifo_wr_en = beat, combinational. fifo_wr_data = req_data of the granted index, combinational.
  - Zero latency from an accepted byte to the FIFO write.
  - On a beat with req_last of the owner high: pkt_done=1 (registered, asserted the following cycle), grant cleared, next state IDLE.
  - Minimum one IDLE bubble between packets.
- fifo_full high: ready=0, fifo_wr_en=0, grant held, no data loss, no reordering.
- Owner drops req_valid mid-packet: grant held, no write.
- Single-byte packet (valid && last on first beat): one write, then IDLE.
- Fairness:
  - With all requesters continuously valid, grants cycle 0,1,2,3,0...
  - A requester is never served twice while another waits.
- rr_ptr/last_owner index arithmetic is modulo NUM_REQ; non-power-of-2 NUM_REQ is supported by explicit wrap compare.
- Reset asserted mid-packet:
  - Immediate return to IDLE, all outputs to reset values.
  - The partial packet is already in the FIFO; the FIFO's own reset discards it.
- req_last without req_valid is ignored.
- grant is always one-hot or zero; a bench assertion checks this.

Optional Feature:
- Macro FIFO_ARB_TIMEOUT_EN.
- Defined:
  - A stall counter increments in BURST on each cycle the owner has req_valid=0. It clears on every beat and on grant.
  - At TIMEOUT_CYC consecutive stall cycles: grant revoked, timeout_err pulses 1 cycle, go to IDLE, no pkt_done.
  - Cycles with the owner valid but fifo_full high do not count as stall.
- Undefined: no counter logic; timeout_err tied 0; a stalled owner holds the grant indefinitely.

Decomposition:
- Shared package holds:
  - the state typedef (IDLE, BURST);
  - the default TIMEOUT_CYC constant;
  - a pure function rr_pick(valid, last_owner) returning the next index.
- One natural sub-module, rr_priority_pick: combinational rotate-and-priority-encode that yields the next index and a found flag. It is reusable by the command FIFO scheduler.
- State, grant, counter and output muxing stay in fifo_pkt_arbiter.

Test Plan:
- Requester 2 sends 3-byte packet 0xA1,0xA2,0xA3 (last on 0xA3), FIFO empty -> grant=0100 one cycle after valid; fifo_wr_en high 3 consecutive cycles with those bytes; pkt_done pulses once; grant=0 after.
- Requesters 0 and 1 each valid with 2-byte packets, same cycle, after reset -> FIFO order is req1 bytes then req0 bytes (rr from last_owner=0 starts at 1); no interleaving.
- Req 3 granted; fifo_full held high 5 cycles after the first byte of 0x10,0x11,0x12 -> req_ready[3]=0 and no fifo_wr_en during those 5 cycles; all 3 bytes written in order afterwards.
- All 4 requesters continuously valid with 1-byte packets, 8 packets total -> grant sequence 1,2,3,0,1,2,3,0; every grant followed by exactly one write.
- rst_n pulsed low mid-packet (after 1 of 4 bytes) -> same cycle grant=0, req_ready=0, fifo_wr_en=0; after release, a new arbitration starts from rr_ptr=0.
- With FIFO_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, owner stalls after 1 byte -> timeout_err pulses in cycle 16 of the stall, grant passes to the next valid requester, no pkt_done. Without the macro -> grant held, timeout_err stays 0.
